cache_ctrl: RTL and testbench

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_pkg.sv | 28 ++
 rtl/cache_tag.sv | 44 ++++
 rtl/cache_ctrl.sv | 179 +++++++++++++++++
 tb/tb_cache_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg -- shared types and constants for the direct-mapped cache controller.
//   state_e      : controller FSM states
//   tag_entry_t  : one tag-array entry {valid, dirty, tag}
//   TAG_W/IDX_W/OFF_W/LINE_W/WORD_W : address split and data widths
package cache_pkg;

    localparam int TAG_W     = 23;
    localparam int IDX_W     = 4;
    localparam int OFF_W     = 5;
    localparam int LINE_W    = 256;
    localparam int WORD_W    = 64;
    localparam int NUM_LINES = 2 ** IDX_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WRITEBACK,
        ST_REFILL,
        ST_WAIT
    } state_e;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
    } tag_entry_t;

endpackage

// File: rtl/cache_tag.sv
// cache_tag -- valid/dirty/tag storage for the 16-entry direct-mapped cache.
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset; clears every valid and dirty bit
//   index_i  : entry index for both the read and the write port
//   entry_o  : combinational read of entry index_i
//   we_i     : write enable, entry_i is stored at index_i on the rising edge
//   entry_i  : entry to write
module cache_tag
    import cache_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [IDX_W-1:0] index_i,
    output tag_entry_t       entry_o,
    input  logic             we_i,
    input  tag_entry_t       entry_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q [NUM_LINES];

    // Only the state bits need clearing; a stale tag is harmless once valid is 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we_i) begin
            valid_q[index_i] <= entry_i.valid;
            dirty_q[index_i] <= entry_i.dirty;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q[index_i] <= entry_i.tag;
        end
    end

    assign entry_o.valid = valid_q[index_i];
    assign entry_o.dirty = dirty_q[index_i];
    assign entry_o.tag   = tag_q[index_i];

endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl -- direct-mapped, write-back, write-allocate cache controller.
//   clk_i / rst_ni            : clock (rising edge), asynchronous active-low reset
//   cpu_req_*                 : CPU request (valid/ready handshake, we, byte addr, wdata)
//   cpu_resp_valid_o/rdata_o  : one-cycle completion pulse with read data
//                               (old word for a write)
//   data_req_index_o/we_o     : external data array index and write enable
//   data_write_o/data_read_i  : data array write line / combinational read line
//   mem_req_*                 : line writeback (we=1) or fill (we=0) request
//   mem_rvalid_i/mem_rdata_i  : fill data return pulse
module cache_ctrl #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 64,
    parameter int LINE_W = 256,
    parameter int IDX_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cpu_req_valid_i,
    output logic              cpu_req_ready_o,
    input  logic              cpu_req_we_i,
    input  logic [ADDR_W-1:0] cpu_req_addr_i,
    input  logic [WORD_W-1:0] cpu_req_wdata_i,
    output logic              cpu_resp_valid_o,
    output logic [WORD_W-1:0] cpu_resp_rdata_o,
    output logic [IDX_W-1:0]  data_req_index_o,
    output logic              data_req_we_o,
    output logic [LINE_W-1:0] data_write_o,
    input  logic [LINE_W-1:0] data_read_i,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic              mem_req_we_o,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    output logic [LINE_W-1:0] mem_req_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [LINE_W-1:0] mem_rdata_i
);

    import cache_pkg::*;

    localparam int BYTE_OFF_W = $clog2(WORD_W / 8);
    localparam int WSEL_W     = OFF_W - BYTE_OFF_W;

    state_e                     state_q;
    state_e                     state_d;
    logic [ADDR_W-1:BYTE_OFF_W] req_addr_q;
    logic                       req_we_q;
    logic [WORD_W-1:0]          req_wdata_q;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WSEL_W-1:0] req_wsel;

    tag_entry_t entry_rd;
    tag_entry_t tag_wr;
    logic       tag_we;
    logic       hit;
    logic       unused_addr_lsb;

    function automatic logic [WORD_W-1:0] get_word(input logic [LINE_W-1:0] line,
                                                   input logic [WSEL_W-1:0] sel);
        return line[int'(sel) * WORD_W +: WORD_W];
    endfunction

    function automatic logic [LINE_W-1:0] put_word(input logic [LINE_W-1:0] line,
                                                   input logic [WSEL_W-1:0] sel,
                                                   input logic [WORD_W-1:0] word);
        logic [LINE_W-1:0] merged;
        merged = line;
        merged[int'(sel) * WORD_W +: WORD_W] = word;
        return merged;
    endfunction

    // Byte-within-word bits never reach the cache.
    assign unused_addr_lsb = ^cpu_req_addr_i[BYTE_OFF_W-1:0];

    assign req_tag  = req_addr_q[ADDR_W-1 -: TAG_W];
    assign req_idx  = req_addr_q[OFF_W +: IDX_W];
    assign req_wsel = req_addr_q[OFF_W-1:BYTE_OFF_W];

    cache_tag u_tag (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .index_i (req_idx),
        .entry_o (entry_rd),
        .we_i    (tag_we),
        .entry_i (tag_wr)
    );

    assign hit = entry_rd.valid && (entry_rd.tag == req_tag);

    // The data array is indexed by the held request for the whole miss, so the
    // writeback line on data_read_i stays stable while memory stalls.
    assign data_req_index_o = req_idx;
    assign mem_req_wdata_o  = data_read_i;
    assign cpu_resp_rdata_o = get_word(data_read_i, req_wsel);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            req_addr_q  <= '0;
            req_we_q    <= 1'b0;
            req_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && cpu_req_valid_i) begin
                req_addr_q  <= cpu_req_addr_i[ADDR_W-1:BYTE_OFF_W];
                req_we_q    <= cpu_req_we_i;
                req_wdata_q <= cpu_req_wdata_i;
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        cpu_req_ready_o  = 1'b0;
        cpu_resp_valid_o = 1'b0;
        data_req_we_o    = 1'b0;
        data_write_o     = put_word(data_read_i, req_wsel, req_wdata_q);
        mem_req_valid_o  = 1'b0;
        mem_req_we_o     = 1'b0;
        mem_req_addr_o   = {req_tag, req_idx, {OFF_W{1'b0}}};
        tag_we           = 1'b0;
        tag_wr.valid     = 1'b1;
        tag_wr.dirty     = 1'b1;
        tag_wr.tag       = req_tag;

        case (state_q)
            ST_IDLE: begin
                cpu_req_ready_o = 1'b1;
                if (cpu_req_valid_i) begin
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (hit) begin
                    cpu_resp_valid_o = 1'b1;
                    state_d          = ST_IDLE;
                    if (req_we_q) begin
                        data_req_we_o = 1'b1;
                        tag_we        = 1'b1;
                    end
                end else if (entry_rd.valid && entry_rd.dirty) begin
                    state_d = ST_WRITEBACK;
                end else begin
                    state_d = ST_REFILL;
                end
            end
            ST_WRITEBACK: begin
                mem_req_valid_o = 1'b1;
                mem_req_we_o    = 1'b1;
                mem_req_addr_o  = {entry_rd.tag, req_idx, {OFF_W{1'b0}}};
                if (mem_req_ready_i) begin
                    state_d = ST_REFILL;
                end
            end
            ST_REFILL: begin
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Install the clean line, then re-run the lookup so reads and
                // write-allocates finish through the ordinary hit path.
                if (mem_rvalid_i) begin
                    data_req_we_o = 1'b1;
                    data_write_o  = mem_rdata_i;
                    tag_we        = 1'b1;
                    tag_wr.dirty  = 1'b0;
                    state_d       = ST_LOOKUP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl -- scoreboard bench for cache_ctrl with a data-array model,
// a backing-memory responder and a flat reference memory image.
module tb_cache_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cpu_req_valid_i;
    logic         cpu_req_ready_o;
    logic         cpu_req_we_i;
    logic [31:0]  cpu_req_addr_i;
    logic [63:0]  cpu_req_wdata_i;
    logic         cpu_resp_valid_o;
    logic [63:0]  cpu_resp_rdata_o;
    logic [3:0]   data_req_index_o;
    logic         data_req_we_o;
    logic [255:0] data_write_o;
    logic [255:0] data_read_i;
    logic         mem_req_valid_o;
    logic         mem_req_ready_i;
    logic         mem_req_we_o;
    logic [31:0]  mem_req_addr_o;
    logic [255:0] mem_req_wdata_o;
    logic         mem_rvalid_i;
    logic [255:0] mem_rdata_i;

    logic [255:0] darr [16];
    logic [255:0] bmem [logic [31:0]];
    logic [255:0] shadow [logic [31:0]];

    logic [63:0]  exp_q [$];
    logic [63:0]  got_q [$];
    logic [31:0]  log_addr [$];
    logic         log_we [$];
    logic [255:0] log_data [$];

    int n_vec = 0, n_miss = 0;
    int cyc = 0;
    int n_resp = 0, n_data_we = 0, n_acc = 0, n_blocked = 0;
    int acc_cyc = 0, resp_lat = 0, resp_cyc = 0, rv_cyc = 0;
    int n_unstable = 0, n_stall_cyc = 0;
    int mem_stall = 0;
    bit hold_fill = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cache_ctrl dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .cpu_req_valid_i  (cpu_req_valid_i),
        .cpu_req_ready_o  (cpu_req_ready_o),
        .cpu_req_we_i     (cpu_req_we_i),
        .cpu_req_addr_i   (cpu_req_addr_i),
        .cpu_req_wdata_i  (cpu_req_wdata_i),
        .cpu_resp_valid_o (cpu_resp_valid_o),
        .cpu_resp_rdata_o (cpu_resp_rdata_o),
        .data_req_index_o (data_req_index_o),
        .data_req_we_o    (data_req_we_o),
        .data_write_o     (data_write_o),
        .data_read_i      (data_read_i),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_we_o     (mem_req_we_o),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_req_wdata_o  (mem_req_wdata_o),
        .mem_rvalid_i     (mem_rvalid_i),
        .mem_rdata_i      (mem_rdata_i)
    );

    // Data array: combinational read, write on the rising edge.
    assign data_read_i = darr[data_req_index_o];
    always @(posedge clk) begin
        if (data_req_we_o) darr[data_req_index_o] <= data_write_o;
    end

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Observer: records responses and event counts between clock edges.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (cpu_req_valid_i && cpu_req_ready_o) begin
                    acc_cyc = cyc;
                    n_acc++;
                end
                if (cpu_req_valid_i && !cpu_req_ready_o) n_blocked++;
                if (cpu_resp_valid_o) begin
                    got_q.push_back(cpu_resp_rdata_o);
                    resp_lat = cyc - acc_cyc;
                    resp_cyc = cyc;
                    n_resp++;
                end
                if (data_req_we_o) n_data_we++;
            end
            if (mem_rvalid_i) rv_cyc = cyc;
        end
    end

    // Backing memory: optional ready stall with stability tracking, fill one
    // cycle after the fill request is accepted (or once hold_fill drops).
    initial begin
        logic [31:0]  a;
        logic         w;
        logic [255:0] d;
        mem_req_ready_i = 1'b0;
        mem_rvalid_i    = 1'b0;
        mem_rdata_i     = '0;
        forever begin
            @(negedge clk);
            if (rst_n && mem_req_valid_o) begin
                a = mem_req_addr_o;
                w = mem_req_we_o;
                d = mem_req_wdata_o;
                for (int i = 0; i < mem_stall; i++) begin
                    @(negedge clk);
                    n_stall_cyc++;
                    if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== a ||
                        mem_req_we_o !== w || (w && mem_req_wdata_o !== d))
                        n_unstable++;
                end
                mem_req_ready_i = 1'b1;
                @(posedge clk);
                #1;
                mem_req_ready_i = 1'b0;
                log_addr.push_back(a);
                log_we.push_back(w);
                log_data.push_back(d);
                if (w) begin
                    bmem[a] = d;
                end else begin
                    while (hold_fill) begin
                        @(posedge clk);
                        #1;
                    end
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = bmem[a];
                    @(posedge clk);
                    #1;
                    mem_rvalid_i = 1'b0;
                end
            end
        end
    end

    // Drive one request; the expected response comes from the reference image.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [63:0] wd,
                         input bit expect_resp);
        logic [31:0]  la;
        logic [255:0] line;
        bit           acc;
        int           k;
        if (expect_resp) begin
            la   = {addr[31:5], 5'b0};
            line = shadow[la];
            exp_q.push_back(line[int'(addr[4:3]) * 64 +: 64]);
            if (we) begin
                line[int'(addr[4:3]) * 64 +: 64] = wd;
                shadow[la] = line;
            end
        end
        cpu_req_we_i    = we;
        cpu_req_addr_i  = addr;
        cpu_req_wdata_i = wd;
        cpu_req_valid_i = 1'b1;
        acc = 1'b0;
        k   = 0;
        while (!acc && k < 300) begin
            @(negedge clk);
            acc = cpu_req_ready_o;
            @(posedge clk);
            #1;
            k++;
        end
        if (!acc) check_val("accept_timeout", 0, 1);
        cpu_req_valid_i = 1'b0;
    endtask

    task automatic wait_resp(input string tag);
        int k;
        k = 0;
        while (got_q.size() == 0 && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (got_q.size() == 0 || exp_q.size() == 0) begin
            check_val({tag, "_timeout"}, got_q.size(), exp_q.size() + 1);
        end else begin
            check_val(tag, got_q.pop_front(), exp_q.pop_front());
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [255:0] line);
        bmem[a]   = line;
        shadow[a] = line;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0, w0, r0, a0, b0, s0, rv0, k;
        logic [255:0] line;

        rst_n           = 1'b0;
        cpu_req_valid_i = 1'b0;
        cpu_req_we_i    = 1'b0;
        cpu_req_addr_i  = '0;
        cpu_req_wdata_i = '0;
        preload(32'h040, {64'h33, 64'hAA, 64'h22, 64'h11});
        preload(32'h240, {64'hC3, 64'hC2, 64'hC1, 64'hC0});
        preload(32'h440, {64'hD3, 64'hD2, 64'hD1, 64'hD0});
        preload(32'h060, {64'hE3, 64'hE2, 64'hE1, 64'hE0});

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_resp_valid", cpu_resp_valid_o, 0);
        check_val("rst_mem_valid", mem_req_valid_o, 0);
        check_val("rst_data_we", data_req_we_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_ready", cpu_req_ready_o, 1);

        // Cold read miss on index 2.
        n0 = log_addr.size();
        issue(1'b0, 32'h040, 64'h0, 1'b1);
        wait_resp("cold_rd");
        check_val("cold_nreq", log_addr.size() - n0, 1);
        check_val("cold_req_addr", log_addr[n0], 32'h040);
        check_val("cold_req_we", log_we[n0], 0);
        check_val("cold_resp_after_fill", resp_cyc - rv_cyc, 1);
        check_val("cold_valid", dut.u_tag.valid_q[2], 1);
        check_val("cold_clean", dut.u_tag.dirty_q[2], 0);

        // Read hit in the same line.
        n0 = log_addr.size();
        w0 = n_data_we;
        issue(1'b0, 32'h050, 64'h0, 1'b1);
        wait_resp("hit_rd");
        check_val("hit_latency", resp_lat, 1);
        check_val("hit_nreq", log_addr.size() - n0, 0);
        check_val("hit_no_we", n_data_we - w0, 0);

        // Write hit to word 1.
        w0 = n_data_we;
        issue(1'b1, 32'h048, 64'h1234, 1'b1);
        wait_resp("wr_hit_old");
        check_val("wr_hit_latency", resp_lat, 1);
        check_val("wr_hit_we_pulses", n_data_we - w0, 1);
        line = darr[2];
        check_val("wr_hit_word1", line[127:64], 64'h1234);
        check_val("wr_hit_dirty", dut.u_tag.dirty_q[2], 1);
        issue(1'b0, 32'h048, 64'h0, 1'b1);
        wait_resp("wr_hit_readback");

        // Conflict miss: dirty writeback then refill, both stalled 3 cycles.
        mem_stall = 3;
        n0 = log_addr.size();
        s0 = n_stall_cyc;
        issue(1'b0, 32'h240, 64'h0, 1'b1);
        wait_resp("evict_rd");
        mem_stall = 0;
        check_val("evict_nreq", log_addr.size() - n0, 2);
        check_val("wb_we", log_we[n0], 1);
        check_val("wb_addr", log_addr[n0], 32'h040);
        line = log_data[n0];
        check_val("wb_word1", line[127:64], 64'h1234);
        check_val("wb_line", log_data[n0], shadow[32'h040]);
        check_val("refill_we", log_we[n0 + 1], 0);
        check_val("refill_addr", log_addr[n0 + 1], 32'h240);
        check_val("stall_cycles", n_stall_cyc - s0, 6);
        check_val("stall_stable", n_unstable, 0);
        check_val("refill_clean", dut.u_tag.dirty_q[2], 0);

        // Reset while waiting for fill data, then a late fill pulse.
        hold_fill = 1'b1;
        n0 = log_addr.size();
        w0 = n_data_we;
        r0 = n_resp;
        rv0 = rv_cyc;
        issue(1'b0, 32'h040, 64'h0, 1'b0);
        k = 0;
        while (log_addr.size() == n0 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_val("abort_fill_req", log_addr.size() - n0, 1);
        @(posedge clk);
        #1;
        check_val("abort_in_wait_ready", cpu_req_ready_o, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("abort_rst_ready", cpu_req_ready_o, 1);
        check_val("abort_rst_data_we", data_req_we_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        hold_fill = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        check_val("late_rvalid_seen", rv_cyc > rv0, 1);
        check_val("late_rvalid_no_we", n_data_we - w0, 0);
        check_val("late_rvalid_no_resp", n_resp - r0, 0);
        check_val("abort_invalid", dut.u_tag.valid_q[2], 0);
        n0 = log_addr.size();
        issue(1'b0, 32'h040, 64'h0, 1'b1);
        wait_resp("rd_after_rst");
        check_val("rd_after_rst_nreq", log_addr.size() - n0, 1);
        check_val("rd_after_rst_addr", log_addr[n0], 32'h040);

        // Second request held valid while the first one misses.
        n0 = log_addr.size();
        a0 = n_acc;
        b0 = n_blocked;
        issue(1'b0, 32'h440, 64'h0, 1'b1);
        issue(1'b0, 32'h45F, 64'h0, 1'b1);
        wait_resp("held_first");
        wait_resp("held_second");
        check_val("held_accepts", n_acc - a0, 2);
        check_val("held_blocked", n_blocked > b0, 1);
        check_val("held_nreq", log_addr.size() - n0, 1);

        // Write miss allocates the line and then merges the word.
        issue(1'b1, 32'h068, 64'hBEEF, 1'b1);
        wait_resp("wr_miss_old");
        check_val("wr_miss_dirty", dut.u_tag.dirty_q[3], 1);
        issue(1'b0, 32'h068, 64'h0, 1'b1);
        wait_resp("wr_miss_readback");

        repeat (3) @(posedge clk);
        #1;
        check_val("sb_drained", got_q.size() + exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
